rr_arbiter8: RTL
================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, 15, maximum number of cycles a grant is held before forced release (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 En  input  1  arbitration enable; when low, no new grant is issued.
REQ-005 r7..r0  input  1 each  request lines from eight requesters.
REQ-006 done  input  1  one-cycle release strobe from the current grant owner.
REQ-007 d7..d0  output  1 each  registered grant vector; one-hot or all-zero; drives the downstream 8-to-3 encoder data inputs.
REQ-008 gv  output  1  grant valid; high exactly when one of d7..d0 is high; drives the downstream encoder enable.
REQ-009 tout  output  1  one-cycle pulse on forced release by timeout.

Function
REQ-010 FSM states: IDLE and GRANT; the state register, grant vector, pointer and hold counter are all clocked by clk and cleared by rst_n.
REQ-011 Search order: start at index ptr+1 and wrap modulo 8 (7 -> 0); the first asserted r[i] in that order wins.
REQ-012 In IDLE with En=1 and any r[i]=1: the next edge loads the one-hot winner into d7..d0, sets gv=1, sets ptr to the winner index, clears the hold counter, and enters GRANT.
REQ-013 In IDLE with En=0 or all r[i]=0: outputs stay all-zero, gv=0, and ptr is unchanged.
REQ-014 Grant latency: 1 cycle from the request edge to the grant edge when idle.
REQ-015 In GRANT: the hold counter (4 bits) increments each cycle; the grant vector is stable and one-hot.
REQ-016 Release conditions in GRANT: done=1, or the owner's request r[ptr]=0, or the hold counter equals HOLD_MAX-1.
REQ-017 On release: the next edge clears d7..d0 and gv and enters IDLE; there is a minimum of one all-zero cycle between consecutive grants.
REQ-018 tout pulses for one cycle, coincident with the cleared grant, only when timeout is the sole release cause; done or a request drop in the same cycle suppresses tout.
REQ-019 done asserted in IDLE is ignored.
REQ-020 En falling during GRANT does not abort the grant; release follows REQ-016 only.
REQ-021 Request changes on non-owner lines during GRANT have no effect until the next IDLE evaluation.
REQ-022 Invariant: d7..d0 is never multi-hot, and gv equals the OR of d7..d0 in every cycle.

Reset
REQ-023 rst_n=0 immediately forces d7..d0=0, gv=0, tout=0, state=IDLE, hold counter=0, and ptr=7, so that index 0 has first priority after reset.
REQ-024 rst_n deasserted mid-grant: the grant is lost; arbitration restarts from ptr=7 on the first edge after reset release.

Verification
REQ-025 Reset release, En=1, r=8'b1000_0001 -> next edge d0=1, gv=1; ptr=0.
REQ-026 From REQ-025, done pulse -> next edge all-zero, gv=0; following edge d7=1 (rotation past 0), ptr=7.
REQ-027 All r=1 held, done pulsed each grant -> grants cycle d0,d1,...,d7,d0, separated by one idle cycle each.
REQ-028 HOLD_MAX=4, single r3 held, no done -> d3 high for 4 cycles; then all-zero with tout=1 for one cycle; then d3 re-granted.
REQ-029 Owner r5 dropped while done=1 in the same cycle at hold count HOLD_MAX-1 -> release occurs, tout stays 0.
REQ-030 En=0 with r2=1 -> no grant; En raised -> d2 granted next edge; En dropped mid-grant -> d2 is held until done.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, done/drop
// release, and a hold-time limit that forces release and flags it on tout.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic En,
  input  logic r7,
  input  logic r6,
  input  logic r5,
  input  logic r4,
  input  logic r3,
  input  logic r2,
  input  logic r1,
  input  logic r0,
  input  logic done,
  output logic d7,
  output logic d6,
  output logic d5,
  output logic d4,
  output logic d3,
  output logic d2,
  output logic d1,
  output logic d0,
  output logic gv,
  output logic tout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       tout_q, tout_d;
  logic       gv_q, gv_d;

  logic [7:0] req;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       win_found;
  logic       owner_req;
  logic       timeout;

  assign req       = {r7, r6, r5, r4, r3, r2, r1, r0};
  assign owner_req = req[ptr_q];
  assign timeout   = (hold_q == HOLD_LAST);

  // Search ptr+1 .. ptr+8 (mod 8); the last candidate is the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (En && win_found) begin
          grant_d = 8'b1 << win_idx;
          ptr_d   = win_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done || !owner_req || timeout) begin
          grant_d = '0;
          hold_d  = '0;
          state_d = IDLE;
          // tout only when the hold limit is the sole reason for release
          tout_d  = timeout && !done && owner_req;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    gv_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= 3'd7;
      hold_q  <= '0;
      tout_q  <= 1'b0;
      gv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tout_q  <= tout_d;
      gv_q    <= gv_d;
    end
  end

  assign {d7, d6, d5, d4, d3, d2, d1, d0} = grant_q;
  assign gv   = gv_q;
  assign tout = tout_q;

endmodule
